spi_master_ctrl: RTL and testbench

SPI master transaction controller: accepts a byte on a start/busy/done handshake, drives a mode-0 (CPOL=0, CPHA=0) SPI transfer on `sclk`/`mosi`/`cs_n`, and returns the byte captured from `miso`. It generates `sclk` internally and uses an edge-detector sub-module on `sclk` to produce the rise and fall strobes that sequence sampling and shifting. It sits between the host-side register logic and the SPI pins.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_edge_detect.sv | 24 ++
 rtl/spi_master_ctrl.sv | 171 +++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM encoding and sizing constants for the SPI master controller.
package spi_pkg;

  // Transaction phases of the SPI master sequencer.
  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    DONE
  } spiState_e;

  localparam int DATA_W_DEFAULT = 8;
  localparam int CLK_DIV_MIN    = 2;

  // Smallest sclk half-period the sequencer can honour; anything below is raised to it.
  function automatic int legalClkDiv(input int clkDiv);
    return (clkDiv < CLK_DIV_MIN) ? CLK_DIV_MIN : clkDiv;
  endfunction

endpackage

// File: rtl/spi_edge_detect.sv
// spi_edge_detect: one-cycle rise/fall strobes for a synchronous level signal.
module spi_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic sigD_q;

  // Remember last cycle's level so a change of level shows up as an edge strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      sigD_q <= 1'b0;
    end else begin
      sigD_q <= sig;
    end
  end

  assign rise = sig & ~sigD_q;
  assign fall = ~sig & sigD_q;

endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: mode-0 SPI master with a start/busy/done host handshake.
// Bit order is MSB first; defining SPI_LSB_FIRST_EN switches both mosi and
// miso to LSB first without changing any timing.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              miso,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n
);

  localparam int HALF = legalClkDiv(CLK_DIV);
  localparam int HW   = $clog2(HALF);
  localparam int BW   = $clog2(DATA_W + 1);

  localparam logic [HW-1:0] HALF_LAST = HW'(HALF - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
  localparam logic [BW-1:0] BIT_ALL   = BW'(DATA_W);

  spiState_e         state_q;
  logic [HW-1:0]     halfCnt_q;
  logic [BW-1:0]     bitCnt_q;
  logic              sclk_q;
  logic              csN_q;
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] rxData_q;
  logic [DATA_W-1:0] txSr_q;
  logic [DATA_W-1:0] rxSr_q;

  logic [DATA_W-1:0] txShift_d;
  logic [DATA_W-1:0] rxShift_d;

  logic sclkRise;
  logic sclkFall;

  // Strobes derived from our own registered sclk pace sampling and shifting.
  spi_edge_detect uSclkEdge (
    .clk   (clk),
    .reset (reset),
    .sig   (sclk_q),
    .rise  (sclkRise),
    .fall  (sclkFall)
  );

  // Shift-register contents after one strobe, in the configured bit order.
  always_comb begin
    txShift_d = txSr_q;
    rxShift_d = rxSr_q;
`ifdef SPI_LSB_FIRST_EN
    txShift_d = {1'b0, txSr_q[DATA_W-1:1]};
    rxShift_d = {miso, rxSr_q[DATA_W-1:1]};
`else
    txShift_d = {txSr_q[DATA_W-2:0], 1'b0};
    rxShift_d = {rxSr_q[DATA_W-2:0], miso};
`endif
  end

  // Transaction sequencer: SETUP and HOLD last one half-period each, XFER
  // alternates sclk high/low halves until every bit has seen a rise and a fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      halfCnt_q <= '0;
      bitCnt_q  <= '0;
      sclk_q    <= 1'b0;
      csN_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rxData_q  <= '0;
      txSr_q    <= '0;
      rxSr_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= SETUP;
            txSr_q    <= tx_data;
            rxSr_q    <= '0;
            csN_q     <= 1'b0;
            busy_q    <= 1'b1;
            halfCnt_q <= '0;
            bitCnt_q  <= '0;
          end
        end

        SETUP: begin
          if (halfCnt_q == HALF_LAST) begin
            halfCnt_q <= '0;
            sclk_q    <= 1'b1;
            state_q   <= XFER;
          end else begin
            halfCnt_q <= halfCnt_q + 1'b1;
          end
        end

        XFER: begin
          if (sclkRise) begin
            rxSr_q <= rxShift_d;
          end
          if (sclkFall) begin
            if (bitCnt_q != BIT_LAST) begin
              txSr_q <= txShift_d;
            end
            bitCnt_q <= bitCnt_q + 1'b1;
          end
          if (halfCnt_q == HALF_LAST) begin
            halfCnt_q <= '0;
            if (sclk_q) begin
              sclk_q <= 1'b0;
            end else if (bitCnt_q == BIT_ALL) begin
              state_q <= HOLD;
            end else begin
              sclk_q <= 1'b1;
            end
          end else begin
            halfCnt_q <= halfCnt_q + 1'b1;
          end
        end

        HOLD: begin
          if (halfCnt_q == HALF_LAST) begin
            halfCnt_q <= '0;
            state_q   <= DONE;
            done_q    <= 1'b1;
            csN_q     <= 1'b1;
            rxData_q  <= rxSr_q;
          end else begin
            halfCnt_q <= halfCnt_q + 1'b1;
          end
        end

        DONE: begin
          state_q  <= IDLE;
          done_q   <= 1'b0;
          busy_q   <= 1'b0;
          bitCnt_q <= '0;
          txSr_q   <= '0;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rxData_q;
  assign sclk    = sclk_q;
  assign cs_n    = csN_q;

`ifdef SPI_LSB_FIRST_EN
  assign mosi = txSr_q[0];
`else
  assign mosi = txSr_q[DATA_W-1];
`endif

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: scoreboard bench for spi_master_ctrl with a slave model
// on the SPI pins and a timing reference derived from whole-transfer arithmetic.
`timescale 1ns/1ps
module tb_spi_master_ctrl;

  localparam int H        = 4;
  localparam int DW       = 8;
  localparam int XFER_LEN = (2 * DW + 2) * H + 1;
  localparam int NO_KILL  = 1 << 30;

  typedef struct {
    int            doneCycle;
    logic [DW-1:0] rx;
  } expect_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [DW-1:0] tx_data;
  logic          miso = 1'b0;
  logic          busy;
  logic          done;
  logic [DW-1:0] rx_data;
  logic          sclk;
  logic          mosi;
  logic          cs_n;

  int            cycleCnt   = 0;
  int            checks     = 0;
  int            failures   = 0;
  bit            checking   = 1'b0;
  int            lastAccept = -100000;
  int            killAt     = NO_KILL;
  logic [DW-1:0] curTx      = '0;
  logic [DW-1:0] curSlave   = '0;
  logic [DW-1:0] expRx      = '0;
  expect_t       sbq[$];

  spi_master_ctrl #(
    .CLK_DIV (H),
    .DATA_W  (DW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .tx_data (tx_data),
    .miso    (miso),
    .busy    (busy),
    .done    (done),
    .rx_data (rx_data),
    .sclk    (sclk),
    .mosi    (mosi),
    .cs_n    (cs_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt++;

  // Bit k of a word as it travels on the wire in the configured order.
  function automatic logic wireBit(input logic [DW-1:0] v, input int k);
    if (k < 0 || k >= DW) return 1'b0;
`ifdef SPI_LSB_FIRST_EN
    return v[k];
`else
    return v[DW-1-k];
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, want %0h", name, cycleCnt, actual, expected);
    end
  endtask

  // Drive one cycle of inputs and decide, from transfer length alone, whether
  // the controller is free to accept a start in this cycle.
  task automatic applyStimulus(input logic st, input logic [DW-1:0] tx,
                               input logic [DW-1:0] slave, input logic rst,
                               output bit accepted);
    @(posedge clk);
    #1;
    start    = st;
    tx_data  = tx;
    reset    = rst;
    accepted = 1'b0;
    if (rst) begin
      killAt = cycleCnt;
      while (sbq.size() > 0 && sbq[$].doneCycle > cycleCnt) void'(sbq.pop_back());
    end else if (st && (cycleCnt > lastAccept + XFER_LEN || cycleCnt > killAt)) begin
      accepted   = 1'b1;
      lastAccept = cycleCnt;
      killAt     = NO_KILL;
      curTx      = tx;
      curSlave   = slave;
      sbq.push_back('{cycleCnt + XFER_LEN, slave});
    end
  endtask

  task automatic idleCycles(input int n);
    bit acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, DW'($urandom), '0, 1'b0, acc);
  endtask

  task automatic waitIdle();
    int budget;
    budget = 0;
    while (sbq.size() > 0 && budget < 300) begin
      idleCycles(1);
      budget++;
    end
    checkOutput("drain_timeout", 32'(sbq.size()), 32'd0);
    idleCycles(2);
  endtask

  task automatic checkResetState(input string tag);
    @(negedge clk);
    checkOutput({tag, "_cs_n"}, 32'(cs_n), 32'd1);
    checkOutput({tag, "_sclk"}, 32'(sclk), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_mosi"}, 32'(mosi), 32'd0);
    checkOutput({tag, "_rx_data"}, 32'(rx_data), 32'd0);
  endtask

  // Slave model: presents its k-th bit while sclk is high after the k-th rise,
  // and random noise whenever sclk is low.
  int   slvRiseCnt = 0;
  int   slvIdx     = 0;
  logic slvPrev    = 1'b0;
  always @(negedge clk) begin
    if (cs_n !== 1'b0) slvRiseCnt = 0;
    if (sclk === 1'b1 && slvPrev !== 1'b1) begin
      slvIdx = slvRiseCnt;
      slvRiseCnt++;
    end
    slvPrev = sclk;
    miso = (sclk === 1'b1) ? wireBit(curSlave, slvIdx) : 1'($urandom);
  end

  // Monitor: per-cycle pin expectations from the transfer offset, plus a
  // scoreboard pop whenever done appears.
  int      monT;
  bit      monAct;
  int      monU;
  logic    expCs;
  logic    expSclk;
  logic    expDone;
  expect_t monE;
  always @(negedge clk) begin
    if (checking) begin
      monT    = cycleCnt - lastAccept;
      monAct  = (monT >= 1) && (monT <= XFER_LEN) && (cycleCnt <= killAt);
      expCs   = !(monAct && monT <= XFER_LEN - 1);
      expSclk = monAct && monT >= H + 1 && monT <= (2 * DW + 1) * H
                && (((monT - H - 1) / H) % 2 == 0);
      expDone = monAct && monT == XFER_LEN;
      checkOutput("pins_busy_csn_sclk_done", 32'({busy, cs_n, sclk, done}),
                  32'({monAct, expCs, expSclk, expDone}));
      if (monAct && monT >= H && monT <= (2 * DW + 1) * H) begin
        monU = monT - H;
        if ((monU % (2 * H)) <= 1 && (monU / (2 * H)) < DW)
          checkOutput("mosi_bit", 32'(mosi), 32'(wireBit(curTx, monU / (2 * H))));
      end
      if (done === 1'b1) begin
        if (sbq.size() == 0) begin
          checkOutput("unexpected_done", 32'd1, 32'd0);
        end else begin
          monE = sbq.pop_front();
          checkOutput("done_cycle", 32'(cycleCnt), 32'(monE.doneCycle));
          expRx = monE.rx;
        end
      end
      checkOutput("rx_data", 32'(rx_data), 32'(expRx));
    end
    if (reset === 1'b1) expRx = '0;
  end

  logic [DW-1:0] heldTx[3]    = '{8'h00, 8'hFF, 8'h81};
  logic [DW-1:0] heldSlave[3];

  initial begin
    bit acc;
    int idx;
    start   = 1'b0;
    tx_data = '0;
    reset   = 1'b1;

    repeat (3) applyStimulus(1'b0, '0, '0, 1'b1, acc);
    applyStimulus(1'b0, '0, '0, 1'b0, acc);
    checking = 1'b1;
    checkResetState("por");

    $display("[TB] single transfer 0xA5 / slave 0x3C with ignored start at cycle 10");
    applyStimulus(1'b1, 8'hA5, 8'h3C, 1'b0, acc);
    checkOutput("accept_a5", 32'(acc), 32'd1);
    idleCycles(9);
    applyStimulus(1'b1, 8'hFF, 8'h99, 1'b0, acc);
    waitIdle();

    $display("[TB] start held for three back-to-back transfers");
    for (int i = 0; i < 3; i++) heldSlave[i] = DW'($urandom);
    idx = 0;
    for (int c = 0; c < 400 && idx < 3; c++) begin
      applyStimulus(1'b1, heldTx[idx], heldSlave[idx], 1'b0, acc);
      if (acc) idx++;
    end
    checkOutput("held_accepts", 32'(idx), 32'd3);
    waitIdle();

    $display("[TB] reset at cycle 30 of a transfer, restart at cycle 35");
    applyStimulus(1'b1, 8'hC3, 8'h5A, 1'b0, acc);
    idleCycles(29);
    applyStimulus(1'b0, '0, '0, 1'b1, acc);
    applyStimulus(1'b0, '0, '0, 1'b0, acc);
    checkResetState("midreset");
    idleCycles(3);
    applyStimulus(1'b1, 8'h3C, 8'hE7, 1'b0, acc);
    checkOutput("accept_after_reset", 32'(acc), 32'd1);
    waitIdle();

    $display("[TB] reset and start in the same cycle");
    applyStimulus(1'b1, 8'h77, 8'h11, 1'b1, acc);
    applyStimulus(1'b0, '0, '0, 1'b0, acc);
    checkResetState("rst_start");
    idleCycles(3);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 3000; c++) begin
      applyStimulus(1'($urandom_range(0, 9) == 0), DW'($urandom), DW'($urandom),
                    1'($urandom_range(0, 399) == 0), acc);
    end
    waitIdle();

    checkOutput("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
